// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM client arbiter.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_WIDTH = 26;
  localparam int unsigned VGA_BURST_LEN    = 16;
  localparam int unsigned BEAT_WIDTH       = 5;
  localparam logic [SDRAM_ADDR_WIDTH-1:0] FRAMEBUFFER_BASE = 26'h3f80000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

  // Read beats the controller must return before completing a transaction.
  function automatic logic [BEAT_WIDTH-1:0] expected_beats(
    input owner_t                owner,
    input logic                  write,
    input logic [BEAT_WIDTH-1:0] burst_len
  );
    if (owner == OWN_VGA) return burst_len;
    if (write)            return BEAT_WIDTH'(0);
    return BEAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-client (VGA burst reader, CPU single word) arbiter onto one SDRAM
// controller port; VGA has priority with alternation on ties.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int unsigned BURST_LEN  = VGA_BURST_LEN
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  vga_sdram_request,
  input  logic [ADDR_WIDTH-1:0] vga_sdram_addr,
  output logic                  vga_sdram_ack,
  output logic [31:0]           vga_sdram_rdata,
  output logic                  vga_sdram_rdvalid,
  output logic                  vga_sdram_complete,

  input  logic                  cpu_sdram_request,
  input  logic                  cpu_sdram_write,
  input  logic [ADDR_WIDTH-1:0] cpu_sdram_addr,
  input  logic [31:0]           cpu_sdram_wdata,
  input  logic [3:0]            cpu_sdram_wmask,
  output logic                  cpu_sdram_ack,
  output logic [31:0]           cpu_sdram_rdata,
  output logic                  cpu_sdram_rdvalid,
  output logic                  cpu_sdram_complete,

  output logic                  mem_request,
  output logic                  mem_write,
  output logic                  mem_burst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rdvalid,
  input  logic                  mem_complete,

  output logic                  protocol_error
);

  localparam logic [BEAT_WIDTH-1:0] BEAT_MAX   = '1;
  localparam logic [BEAT_WIDTH-1:0] BURST_BEAT = BEAT_WIDTH'(BURST_LEN);

  state_t                  state, next_state;
  owner_t                  owner, next_owner;
  owner_t                  last_owner, next_last_owner;
  logic [BEAT_WIDTH-1:0]   beat_cnt, next_beat_cnt, beats_now;
  logic                    next_mem_request, next_mem_write, next_mem_burst;
  logic [ADDR_WIDTH-1:0]   next_mem_addr;
  logic [31:0]             next_mem_wdata;
  logic [3:0]              next_mem_wmask;
  logic                    next_protocol_error;
  logic                    grant_cpu;

  logic in_issue, in_data, own_vga, own_cpu;
  assign in_issue = (state == ST_ISSUE);
  assign in_data  = (state == ST_DATA);
  assign own_vga  = (owner == OWN_VGA);
  assign own_cpu  = (owner == OWN_CPU);

  // Strobes route combinationally to the current owner only.
  assign vga_sdram_ack      = in_issue && own_vga && mem_ack;
  assign cpu_sdram_ack      = in_issue && own_cpu && mem_ack;
  assign vga_sdram_rdata    = in_data ? mem_rdata : 32'd0;
  assign cpu_sdram_rdata    = in_data ? mem_rdata : 32'd0;
  assign vga_sdram_rdvalid  = in_data && own_vga && mem_rdvalid;
  assign cpu_sdram_rdvalid  = in_data && own_cpu && mem_rdvalid;
  assign vga_sdram_complete = in_data && own_vga && mem_complete;
  assign cpu_sdram_complete = in_data && own_cpu && mem_complete;

  // Beat count including this cycle's beat, so a final beat arriving with
  // complete is seen by the completion check.
  assign beats_now = (mem_rdvalid && beat_cnt != BEAT_MAX) ? beat_cnt + BEAT_WIDTH'(1) : beat_cnt;

  always_comb begin
    next_state          = state;
    next_owner          = owner;
    next_last_owner     = last_owner;
    next_beat_cnt       = beat_cnt;
    next_mem_request    = mem_request;
    next_mem_write      = mem_write;
    next_mem_burst      = mem_burst;
    next_mem_addr       = mem_addr;
    next_mem_wdata      = mem_wdata;
    next_mem_wmask      = mem_wmask;
    next_protocol_error = protocol_error;
    grant_cpu           = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (vga_sdram_request || cpu_sdram_request) begin
          grant_cpu        = cpu_sdram_request && (!vga_sdram_request || last_owner == OWN_VGA);
          next_state       = ST_ISSUE;
          next_mem_request = 1'b1;
          if (grant_cpu) begin
            next_owner     = OWN_CPU;
            next_mem_burst = 1'b0;
            next_mem_write = cpu_sdram_write;
            next_mem_addr  = cpu_sdram_addr;
            next_mem_wdata = cpu_sdram_wdata;
            next_mem_wmask = cpu_sdram_wmask;
          end else begin
            next_owner     = OWN_VGA;
            next_mem_burst = 1'b1;
            next_mem_write = 1'b0;
            next_mem_addr  = vga_sdram_addr;
            next_mem_wdata = 32'd0;
            next_mem_wmask = 4'd0;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          next_mem_request = 1'b0;
          next_state       = ST_DATA;
          next_beat_cnt    = '0;
          next_last_owner  = owner;
        end
      end
      ST_DATA: begin
        next_beat_cnt = beats_now;
        if (mem_complete) begin
          next_state = ST_IDLE;
          if (beats_now != expected_beats(owner, mem_write, BURST_BEAT))
            next_protocol_error = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // Controller strobes in a state that does not expect them.
    if ((mem_ack && !in_issue) || ((mem_rdvalid || mem_complete) && !in_data))
      next_protocol_error = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      owner          <= OWN_VGA;
      last_owner     <= OWN_CPU;
      beat_cnt       <= '0;
      mem_request    <= 1'b0;
      mem_write      <= 1'b0;
      mem_burst      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= 32'd0;
      mem_wmask      <= 4'd0;
      protocol_error <= 1'b0;
    end else begin
      state          <= next_state;
      owner          <= next_owner;
      last_owner     <= next_last_owner;
      beat_cnt       <= next_beat_cnt;
      mem_request    <= next_mem_request;
      mem_write      <= next_mem_write;
      mem_burst      <= next_mem_burst;
      mem_addr       <= next_mem_addr;
      mem_wdata      <= next_mem_wdata;
      mem_wmask      <= next_mem_wmask;
      protocol_error <= next_protocol_error;
    end
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Responder end of the SDRAM client protocol used by the VGA framebuffer reader.
- Accepts requests from two clients and serialises them onto the single SDRAM controller port:
  - VGA: 16-word burst reads.
  - CPU: single-word read or write.
- Routes read data, valid and completion strobes back to the owning client only.
- VGA has priority because it is real-time; a fairness rule stops the CPU from starving.

Parameters:
- ADDR_WIDTH, 26, width of client and controller word addresses.
- BURST_LEN, 16, words per VGA burst (64 bytes).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vga_sdram_request  in  1  VGA burst read request; held until ack.
- vga_sdram_addr  in  ADDR_WIDTH  burst start address.
- vga_sdram_ack  out  1  request accepted.
- vga_sdram_rdata  out  32  read data.
- vga_sdram_rdvalid  out  1  rdata valid, one pulse per word.
- vga_sdram_complete  out  1  burst finished.
- cpu_sdram_request  in  1  CPU request; held until ack.
- cpu_sdram_write  in  1  1 = write, 0 = read.
- cpu_sdram_addr  in  ADDR_WIDTH  word address.
- cpu_sdram_wdata  in  32  write data.
- cpu_sdram_wmask  in  4  byte enables.
- cpu_sdram_ack / cpu_sdram_rdata(32) / cpu_sdram_rdvalid / cpu_sdram_complete  out  same meaning as the VGA signals.
- mem_request  out  1  to the SDRAM controller.
- mem_write  out  1  write strobe to the controller.
- mem_burst  out  1  1 = BURST_LEN-word read, 0 = single word.
- mem_addr  out  ADDR_WIDTH  controller address.
- mem_wdata  out  32  write data to the controller.
- mem_wmask  out  4  byte enables to the controller.
- mem_ack  in  1  controller accepted the request.
- mem_rdata  in  32  read data from the controller.
- mem_rdvalid  in  1  read data valid.
- mem_complete  in  1  transaction finished.
- protocol_error  out  1  sticky error flag.

Behaviour:
- States: IDLE, ISSUE, DATA.
- Owner register: owner ∈ {VGA, CPU}.
- last_owner register: records which client was served last.
- IDLE grant:
  - Only vga_request set: grant VGA.
  - Only cpu_request set: grant CPU.
  - Both set: grant VGA unless last_owner == VGA, then grant CPU.
  - Grant is a clock edge. Next cycle: state = ISSUE, mem_request = 1.
  - mem_addr, mem_burst, mem_write, mem_wdata and mem_wmask are captured from the granted client at that edge and held stable through ISSUE.
  - VGA grant: mem_burst = 1, mem_write = 0.
  - CPU grant: mem_burst = 0, mem_write = cpu_sdram_write.
- ISSUE:
  - mem_request held high until mem_ack.
  - Owner's *_ack = mem_ack, combinational, same cycle, single-cycle pulse.
  - On mem_ack: mem_request = 0 at the next edge; state = DATA; beat counter cleared; last_owner = owner.
- DATA:
  - Both *_rdata = mem_rdata, combinational.
  - Owner's *_rdvalid = mem_rdvalid; the non-owner's is 0.
  - Owner's *_complete = mem_complete.
  - Beat counter (5 bits) increments on each mem_rdvalid, saturating at 31.
  - On mem_complete: return to IDLE. A new grant is possible the following cycle.
- Expected beats: VGA read = BURST_LEN; CPU read = 1; CPU write = 0.
  - Completion with a beat count other than expected sets protocol_error.
  - Any rdvalid, complete or ack outside the state that expects it also sets protocol_error.
  - protocol_error is cleared only by reset.
- A request deasserting in ISSUE is ignored; the transaction completes and the ack still pulses.
- A client's request is not re-sampled while that client owns the bus.
- Simultaneous mem_rdvalid and mem_complete on the last beat: the beat is counted before the check.
- Reset:
  - state = IDLE, owner = VGA, last_owner = CPU (VGA wins the first tie).
  - All outputs 0, beat counter 0, protocol_error 0.
  - Any in-flight transaction is abandoned; the controller shares the same reset.
- Worst-case CPU latency: one VGA burst plus its own transaction. Worst-case VGA latency: one CPU transaction.

Decomposition:
- Shared package sdram_pkg:
  - state enum (IDLE, ISSUE, DATA).
  - owner enum (VGA, CPU).
  - SDRAM_ADDR_WIDTH = 26.
  - VGA_BURST_LEN = 16.
  - FRAMEBUFFER_BASE = 26'h3f80000.
- No sub-module. All control lives in one always_comb plus one always_ff, with next_* signals.

Test Plan:
- VGA alone, addr 0x3f80000; controller acks after 3 cycles and returns 16 beats 0x00000000..0x0000000F, then complete:
  - vga_ack pulses once.
  - Exactly 16 vga_rdvalid pulses with matching data.
  - One vga_complete.
  - No cpu_* strobes.
  - protocol_error = 0.
- CPU write, addr 0x100, wdata 0xDEADBEEF, wmask 0xF:
  - mem_write = 1, mem_burst = 0, fields match.
  - cpu_complete with zero rdvalid.
  - protocol_error = 0.
- CPU read, addr 0x100, controller returns 0xDEADBEEF:
  - One cpu_rdvalid with 0xDEADBEEF.
  - vga_rdvalid stays 0 throughout.
- VGA and CPU request in the same cycle after reset:
  - VGA granted first.
  - With VGA re-requesting immediately, CPU is granted next; grants then alternate.
- Controller returns only 15 beats on a VGA burst then complete:
  - protocol_error = 1 and stays set until reset.
- Reset asserted mid-burst after 5 beats:
  - Next cycle all outputs 0, state IDLE.
  - A fresh VGA request is granted normally.
